autosym_lin_projector: RTL and testbench

Sequential GF(2) linear projector for autosymmetric functions: the front end that maps a full input vector x into the restricted-space vector y = A·x consumed by restriction cores (14-input single-output logic).
- Each output bit is the XOR-parity of a masked subset of inputs.
- Rows of A are programmable through a config port.
- Evaluation is serial: one row per clock.
- Sits between the vector source and the restriction core, with valid/ready on both sides.

---
 rtl/autosym_lin_projector_pkg.sv | 20 ++
 rtl/autosym_lin_projector_if.sv | 22 ++
 rtl/autosym_lin_projector_gf2_dot.sv | 10 +
 rtl/autosym_lin_projector.sv | 120 ++++++++++++
 tb/tb_autosym_lin_projector.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/autosym_lin_projector_pkg.sv
// Shared constants, FSM state type and the identity-row helper for the
// autosymmetric linear projector.
package autosym_pkg;

    localparam int N_IN_DEF  = 16;
    localparam int N_OUT_DEF = 14;
    localparam int ROW_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Callers truncate to their own row width.
    function automatic logic [ROW_MAX_W-1:0] identity_row(input int idx);
        identity_row = {{(ROW_MAX_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/autosym_lin_projector_if.sv
// Vector-in / vector-out valid-ready stream bundle for the projector.
interface autosym_lin_projector_if #(
    parameter int N_IN  = 16,
    parameter int N_OUT = 14
);
    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   in_vec;
    logic              out_valid;
    logic              out_ready;
    logic [N_OUT-1:0]  out_vec;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_vec
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_vec
    );
endinterface

// File: rtl/autosym_lin_projector_gf2_dot.sv
// GF(2) inner product: masked AND followed by XOR reduction.
module gf2_dot #(
    parameter int N_IN = 16
) (
    input  logic [N_IN-1:0] mask,
    input  logic [N_IN-1:0] vec,
    output logic            parity
);
    assign parity = ^(mask & vec);
endmodule

// File: rtl/autosym_lin_projector.sv
// Serial GF(2) projector y = A*x, one matrix row per clock.
// Optional AUTOSYM_AFFINE_EN adds a per-row constant bit (affine projection).
module autosym_lin_projector
    import autosym_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         cfg_we,
    input  logic [(N_OUT > 1 ? $clog2(N_OUT) : 1)-1:0]   cfg_addr,
    input  logic [N_IN-1:0]                              cfg_data,
`ifdef AUTOSYM_AFFINE_EN
    input  logic                                         cfg_cbit,
`endif
    output logic                                         cfg_busy,
    autosym_lin_projector_if.slave                       io
);
    localparam int CNT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_IN-1:0]     x_q, x_d;
    logic [N_OUT-1:0]    acc_q, acc_d;
    logic [N_IN-1:0]     rows_q [N_OUT];
    logic [N_IN-1:0]     rows_d [N_OUT];
    logic [N_OUT-1:0]    cbit_q, cbit_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                cfg_busy_q, cfg_busy_d;
    logic                dot_bit;
    logic                row_bit;

    gf2_dot #(.N_IN(N_IN)) u_dot (
        .mask   (rows_q[cnt_q]),
        .vec    (x_q),
        .parity (dot_bit)
    );

    assign row_bit = dot_bit ^ cbit_q[cnt_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        acc_d   = acc_q;
        rows_d  = rows_q;
        cbit_d  = cbit_q;
        case (state_q)
            IDLE: begin
                // The write lands on the same edge as an accept, so the
                // accepted vector already sees the new row.
                if (cfg_we && (int'(cfg_addr) < N_OUT)) begin
                    rows_d[cfg_addr] = cfg_data;
`ifdef AUTOSYM_AFFINE_EN
                    cbit_d[cfg_addr] = cfg_cbit;
`endif
                end
                if (io.in_valid && in_ready_q) begin
                    x_d     = io.in_vec;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                acc_d[cnt_q] = row_bit;
                if (cnt_q == CNT_W'(N_OUT - 1)) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (io.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == HOLD);
        cfg_busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            cbit_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cfg_busy_q  <= 1'b0;
            for (int i = 0; i < N_OUT; i++) begin
                rows_q[i] <= N_IN'(identity_row(i));
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            cbit_q      <= cbit_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cfg_busy_q  <= cfg_busy_d;
            rows_q      <= rows_d;
        end
    end

    // The latched operand needs no reset: it is always loaded before use.
    always_ff @(posedge clk) begin
        x_q <= x_d;
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.out_vec   = acc_q;
    assign cfg_busy     = cfg_busy_q;

endmodule

// File: tb/tb_autosym_lin_projector.sv
// Randomized self-checking bench for autosym_lin_projector against a
// matrix/parity reference model; covers AUTOSYM_AFFINE_EN when defined.
module tb_autosym_lin_projector;
    localparam int NI = 16;
    localparam int NO = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [3:0]    cfg_addr;
    logic [NI-1:0] cfg_data;
    logic          cfg_cbit;
    logic          cfg_busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [NI-1:0] m [NO];
    logic [NO-1:0] c;

    autosym_lin_projector_if #(.N_IN(NI), .N_OUT(NO)) io ();

    autosym_lin_projector #(.N_IN(NI), .N_OUT(NO)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
`ifdef AUTOSYM_AFFINE_EN
        .cfg_cbit (cfg_cbit),
`endif
        .cfg_busy (cfg_busy),
        .io       (io)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [NO-1:0] model_y(input logic [NI-1:0] x);
        logic [NO-1:0] y;
        for (int i = 0; i < NO; i++) begin
            y[i] = 1'($countones(m[i] & x) % 2) ^ c[i];
        end
        return y;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NO; i++) m[i] = NI'(1) << i;
        c = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("rst_in_ready", 32'(io.in_ready), 1);
        check("rst_out_valid", 32'(io.out_valid), 0);
        check("rst_out_vec", 32'(io.out_vec), 0);
        check("rst_cfg_busy", 32'(cfg_busy), 0);
    endtask

    task automatic cfg_write(input int addr, input logic [NI-1:0] data, input logic cb);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = 4'(addr);
        cfg_data = data;
        cfg_cbit = cb;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        if (addr < NO) begin
            m[addr] = data;
`ifdef AUTOSYM_AFFINE_EN
            c[addr] = cb;
`endif
        end
    endtask

    // Latency is counted in edges after the accepting edge; N_OUT edges
    // means out_valid is first seen in handshake cycle + N_OUT + 1.
    task automatic run_vec(input logic [NI-1:0] x, input int hold, input bit poke_mid,
                           input bit cfg_same, input int caddr, input logic [NI-1:0] cdata,
                           output logic [NO-1:0] got);
        logic [NO-1:0] exp;
        int lat;
        @(negedge clk);
        check("pre_in_ready", 32'(io.in_ready), 1);
        io.in_valid = 1'b1;
        io.in_vec = x;
        io.out_ready = 1'b0;
        if (cfg_same) begin
            cfg_we = 1'b1;
            cfg_addr = 4'(caddr);
            cfg_data = cdata;
            cfg_cbit = 1'b0;
            if (caddr < NO) m[caddr] = cdata;
        end
        exp = model_y(x);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        cfg_we = 1'b0;
        io.in_vec = NI'($urandom);
        lat = 0;
        while (!io.out_valid && lat < 40) begin
            check("busy_compute", 32'(cfg_busy), 1);
            check("rdy_compute", 32'(io.in_ready), 0);
            if (poke_mid && lat == 3) begin
                cfg_we = 1'b1;
                cfg_addr = 4'd2;
                cfg_data = '0;
            end
            @(posedge clk);
            #1;
            cfg_we = 1'b0;
            lat++;
        end
        check("latency", lat, NO);
        got = io.out_vec;
        check("out_vec", 32'(got), 32'(exp));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(io.out_valid), 1);
            check("hold_vec", 32'(io.out_vec), 32'(exp));
            check("hold_rdy", 32'(io.in_ready), 0);
        end
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        check("post_valid", 32'(io.out_valid), 0);
        check("post_rdy", 32'(io.in_ready), 1);
        check("post_busy", 32'(cfg_busy), 0);
        check("post_vec", 32'(io.out_vec), 32'(exp));
    endtask

    initial begin
        logic [NO-1:0] got;
        int lat;
        rst = 1'b1;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        cfg_cbit = 1'b0;
        io.in_valid = 1'b0;
        io.in_vec = '0;
        io.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        run_vec(16'hA5C3, 0, 0, 0, 0, '0, got);
        check("tp_identity", 32'(got), 32'h25C3);

        cfg_write(0, 16'hFFFF, 1'b0);
        for (int i = 1; i < NO; i++) cfg_write(i, 16'h0000, 1'b0);
        run_vec(16'h0007, 0, 0, 0, 0, '0, got);
        check("tp_par7", 32'(got), 32'h0001);
        run_vec(16'h0003, 0, 0, 0, 0, '0, got);
        check("tp_par3", 32'(got), 32'h0000);

        // Row 2 nonzero, then a mid-compute write of zero must be ignored.
        cfg_write(2, 16'h00F0, 1'b0);
        run_vec(16'h0010, 0, 1, 0, 0, '0, got);
        check("tp_poke_bit2", 32'(got[2]), 1);
        run_vec(16'h0030, 0, 0, 0, 0, '0, got);
        check("tp_poke_next", 32'(got[2]), 0);
        run_vec(16'h0070, 0, 0, 0, 0, '0, got);
        check("tp_poke_next2", 32'(got[2]), 1);

        run_vec(16'h1234, 20, 0, 0, 0, '0, got);

        // Write and accept in the same cycle: vector sees the new row.
        run_vec(16'h8000, 0, 0, 1, 5, 16'h8000, got);
        check("tp_same_cycle", 32'(got[5]), 1);
        // Out-of-range addresses are dropped.
        cfg_write(15, 16'hFFFF, 1'b1);
        cfg_write(14, 16'hFFFF, 1'b1);
        run_vec(16'hFFFF, 0, 0, 0, 0, '0, got);

        for (int t = 0; t < 25; t++) begin
            cfg_write(int'($urandom_range(0, 15)), NI'($urandom), 1'($urandom));
            run_vec(NI'($urandom), int'($urandom_range(0, 3)), 0, 0, 0, '0, got);
        end

        // Reset with the row counter at 5 mid-compute.
        @(negedge clk);
        io.in_valid = 1'b1;
        io.in_vec = NI'($urandom);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        lat = 0;
        while (lat < 5) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("mid_busy", 32'(cfg_busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("midrst_valid", 32'(io.out_valid), 0);
        check("midrst_rdy", 32'(io.in_ready), 1);
        check("midrst_busy", 32'(cfg_busy), 0);
        run_vec(16'hBEEF, 0, 0, 0, 0, '0, got);
        check("midrst_identity", 32'(got), 32'h3EEF);

`ifdef AUTOSYM_AFFINE_EN
        cfg_write(0, 16'h0001, 1'b1);
        run_vec(16'h0000, 0, 0, 0, 0, '0, got);
        check("tp_affine", 32'(got), 32'h0001);
        for (int t = 0; t < 10; t++) begin
            cfg_write(int'($urandom_range(0, 13)), NI'($urandom), 1'($urandom));
            run_vec(NI'($urandom), 0, 0, 0, 0, '0, got);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
